csi_tx_hs_clk_lane: RTL and testbench
=====================================

CSI_TX_HS_CLK_LANE -- requirements
Module: csi_tx_hs_clk_lane

Interface
REQ-001 SHALL provide parameter T_LPX, default 2, LP-01 duration in byte_clock cycles (1..255).
REQ-002 SHALL provide parameter T_PREPARE, default 2, LP-00 duration in cycles (1..255).
REQ-003 SHALL provide parameter T_ZERO, default 8, HS-0 duration before clocking, in cycles (1..255).
REQ-004 SHALL provide parameters T_POST (default 4), T_TRAIL (default 2) and T_HS_EXIT (default 3), in cycles (1..255).
REQ-005 SHALL provide: byte_clock  input  1  sole clock.
REQ-006 SHALL provide: reset_n  input  1  asynchronous active-low reset.
REQ-007 SHALL provide: hs_req  input  1  request for the HS clock to run.
REQ-008 SHALL provide: data_busy  input  1  data lanes still in HS; blocks clock stop.
REQ-009 SHALL provide: lp_p, lp_n  output  1 each  LP line drive levels.
REQ-010 SHALL provide: hs_oe  output  1  HS differential driver enable.
REQ-011 SHALL provide: hs_clk_run  output  1  serializer emits the toggling clock pattern (0 = all-zero pattern).
REQ-012 SHALL provide: clk_ready  output  1  HS clock is stable; data lanes may start.

Function
REQ-013 SHALL implement FSM states IDLE, LP01, LP00, HS_ZERO, HS_CLK, HS_POST, HS_TRAIL, HS_EXIT; all outputs registered.
REQ-014 SHALL drive outputs per state: IDLE/HS_EXIT lp=11, hs_oe=0; LP01 lp=01; LP00 lp=00; HS_ZERO/HS_TRAIL hs_oe=1, hs_clk_run=0; HS_CLK/HS_POST hs_oe=1, hs_clk_run=1; lp=00 whenever hs_oe=1.
REQ-015 SHALL assert clk_ready only in HS_CLK.
REQ-016 SHALL keep each timed state (LP01, LP00, HS_ZERO, HS_POST, HS_TRAIL, HS_EXIT) for exactly its parameter's cycle count, using one 8-bit down-counter loaded on state entry.
REQ-017 SHALL move IDLE->LP01 on the cycle after hs_req is sampled high in IDLE; then LP01->LP00->HS_ZERO->HS_CLK on counter expiry.
REQ-018 SHALL remain in HS_CLK at least one cycle and exit to HS_POST only when hs_req=0 and data_busy=0 in the same cycle.
REQ-019 SHALL run HS_POST->HS_TRAIL->HS_EXIT->IDLE on counter expiry.
REQ-020 SHALL ignore hs_req deassertion during LP01..HS_ZERO (startup completes to HS_CLK) and hs_req assertion during HS_POST..HS_EXIT (shutdown completes to IDLE, then restarts if hs_req still high).
REQ-021 SHALL treat a parameter value of 0 as 1.

Reset
REQ-022 SHALL on reset_n low immediately force state IDLE, lp_p=1, lp_n=1, hs_oe=0, hs_clk_run=0, clk_ready=0, counter=0, including mid-sequence.
REQ-023 SHALL evaluate hs_req from the first byte_clock edge after reset_n deasserts.

Configuration
REQ-024 SHALL, with macro CSI_TX_CLK_CONTINUOUS_EN defined, ignore hs_req: leave IDLE automatically on the first edge after reset, run the startup sequence, and stay in HS_CLK permanently regardless of hs_req/data_busy.
REQ-025 SHALL, without CSI_TX_CLK_CONTINUOUS_EN, operate in non-continuous mode exactly as REQ-017..REQ-020.

Verification (T_LPX=2, T_PREPARE=3, T_ZERO=10, T_POST=4, T_TRAIL=3, T_HS_EXIT=5)
REQ-026 SHALL cover startup: hs_req high sampled in IDLE at cycle N -> lp=01 at N+1..N+2, lp=00 at N+3..N+5, hs_oe=1/hs_clk_run=0 at N+6..N+15, clk_ready=1 from N+16.
REQ-027 SHALL cover stop: in HS_CLK, hs_req low at cycle M with data_busy=0 -> hs_clk_run=1 at M+1..M+4, hs_clk_run=0 at M+5..M+7, lp=11/hs_oe=0 from M+8, IDLE at M+13.
REQ-028 SHALL cover data_busy hold: hs_req low while data_busy=1 for 20 cycles -> clk_ready remains 1 throughout; HS_POST entered the cycle after data_busy falls.
REQ-029 SHALL cover reassert during shutdown: hs_req high again in HS_TRAIL -> sequence completes through HS_EXIT (5 cycles lp=11), one IDLE cycle, then LP01.
REQ-030 SHALL cover async reset: reset_n low during HS_ZERO -> outputs at reset values (lp=11, hs_oe=0) without waiting for a clock edge.
REQ-031 SHALL cover continuous mode: CSI_TX_CLK_CONTINUOUS_EN defined, hs_req tied 0 -> clk_ready=1 by cycle 17 after reset release and stays 1 for 1000 cycles.

Source files
------------

// File: rtl/csi_tx_hs_clk_lane.sv
// CSI-2 transmit clock lane controller: sequences the LP-11 -> LP-01 -> LP-00 -> HS-0 ->
// HS clock entry and the HS clock -> post -> trail -> LP-11 exit. All outputs are registered.
// Optional feature: define CSI_TX_CLK_CONTINUOUS_EN for a continuously running HS clock.
module csi_tx_hs_clk_lane #(
  parameter int unsigned T_LPX     = 2,
  parameter int unsigned T_PREPARE = 2,
  parameter int unsigned T_ZERO    = 8,
  parameter int unsigned T_POST    = 4,
  parameter int unsigned T_TRAIL   = 2,
  parameter int unsigned T_HS_EXIT = 3
) (
  input  logic byte_clock,
  input  logic reset_n,
  input  logic hs_req,
  input  logic data_busy,
  output logic lp_p,
  output logic lp_n,
  output logic hs_oe,
  output logic hs_clk_run,
  output logic clk_ready
);

`ifdef CSI_TX_CLK_CONTINUOUS_EN
  localparam bit ContEn = 1'b1;
`else
  localparam bit ContEn = 1'b0;
`endif

  // Counter reload values: state lasts (load + 1) cycles; a zero parameter behaves as 1.
  localparam logic [7:0] LpxLoad   = (T_LPX     == 0) ? 8'd0 : 8'(T_LPX - 1);
  localparam logic [7:0] PrepLoad  = (T_PREPARE == 0) ? 8'd0 : 8'(T_PREPARE - 1);
  localparam logic [7:0] ZeroLoad  = (T_ZERO    == 0) ? 8'd0 : 8'(T_ZERO - 1);
  localparam logic [7:0] PostLoad  = (T_POST    == 0) ? 8'd0 : 8'(T_POST - 1);
  localparam logic [7:0] TrailLoad = (T_TRAIL   == 0) ? 8'd0 : 8'(T_TRAIL - 1);
  localparam logic [7:0] ExitLoad  = (T_HS_EXIT == 0) ? 8'd0 : 8'(T_HS_EXIT - 1);

  typedef enum logic [2:0] {
    StIdle, StLp01, StLp00, StHsZero, StHsClk, StHsPost, StHsTrail, StHsExit
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       lp_p_q, lp_p_d, lp_n_q, lp_n_d;
  logic       hs_oe_q, hs_oe_d, run_q, run_d, ready_q, ready_d;
  logic       expired;

  assign expired = (cnt_q == 8'd0);

  // Next-state and down-counter: counter is reloaded on entry to each timed state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (hs_req || ContEn) begin
          state_d = StLp01;
          cnt_d   = LpxLoad;
        end
      end
      StLp01: begin
        if (expired) begin
          state_d = StLp00;
          cnt_d   = PrepLoad;
        end else cnt_d = cnt_q - 8'd1;
      end
      StLp00: begin
        if (expired) begin
          state_d = StHsZero;
          cnt_d   = ZeroLoad;
        end else cnt_d = cnt_q - 8'd1;
      end
      StHsZero: begin
        if (expired) begin
          state_d = StHsClk;
          cnt_d   = 8'd0;
        end else cnt_d = cnt_q - 8'd1;
      end
      StHsClk: begin
        // Data lanes must have left HS before the clock may stop.
        if (!ContEn && !hs_req && !data_busy) begin
          state_d = StHsPost;
          cnt_d   = PostLoad;
        end
      end
      StHsPost: begin
        if (expired) begin
          state_d = StHsTrail;
          cnt_d   = TrailLoad;
        end else cnt_d = cnt_q - 8'd1;
      end
      StHsTrail: begin
        if (expired) begin
          state_d = StHsExit;
          cnt_d   = ExitLoad;
        end else cnt_d = cnt_q - 8'd1;
      end
      StHsExit: begin
        if (expired) begin
          state_d = StIdle;
          cnt_d   = 8'd0;
        end else cnt_d = cnt_q - 8'd1;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs align with the state register.
  always_comb begin
    lp_p_d  = 1'b1;
    lp_n_d  = 1'b1;
    hs_oe_d = 1'b0;
    run_d   = 1'b0;
    ready_d = 1'b0;
    unique case (state_d)
      StLp01: lp_p_d = 1'b0;
      StLp00: begin
        lp_p_d = 1'b0;
        lp_n_d = 1'b0;
      end
      StHsZero, StHsTrail: begin
        lp_p_d  = 1'b0;
        lp_n_d  = 1'b0;
        hs_oe_d = 1'b1;
      end
      StHsClk: begin
        lp_p_d  = 1'b0;
        lp_n_d  = 1'b0;
        hs_oe_d = 1'b1;
        run_d   = 1'b1;
        ready_d = 1'b1;
      end
      StHsPost: begin
        lp_p_d  = 1'b0;
        lp_n_d  = 1'b0;
        hs_oe_d = 1'b1;
        run_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // State, counter and output registers with asynchronous reset to LP-11.
  always_ff @(posedge byte_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      lp_p_q  <= 1'b1;
      lp_n_q  <= 1'b1;
      hs_oe_q <= 1'b0;
      run_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lp_p_q  <= lp_p_d;
      lp_n_q  <= lp_n_d;
      hs_oe_q <= hs_oe_d;
      run_q   <= run_d;
      ready_q <= ready_d;
    end
  end

  assign lp_p       = lp_p_q;
  assign lp_n       = lp_n_q;
  assign hs_oe      = hs_oe_q;
  assign hs_clk_run = run_q;
  assign clk_ready  = ready_q;

endmodule

// File: tb/tb_csi_tx_hs_clk_lane.sv
// Directed bench for csi_tx_hs_clk_lane with T_LPX=2, T_PREPARE=3, T_ZERO=10, T_POST=4,
// T_TRAIL=3, T_HS_EXIT=5. Observed vector is {lp_p, lp_n, hs_oe, hs_clk_run, clk_ready}.
module tb_csi_tx_hs_clk_lane;

  localparam logic [4:0] OIdle  = 5'b11000;  // IDLE and HS_EXIT
  localparam logic [4:0] OLp01  = 5'b01000;
  localparam logic [4:0] OLp00  = 5'b00000;
  localparam logic [4:0] OZero  = 5'b00100;  // HS_ZERO and HS_TRAIL
  localparam logic [4:0] OClk   = 5'b00111;
  localparam logic [4:0] OPost  = 5'b00110;

  logic clk = 1'b0;
  logic reset_n, hs_req, data_busy;
  logic lp_p, lp_n, hs_oe, hs_clk_run, clk_ready;
  logic [4:0] obs;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign obs = {lp_p, lp_n, hs_oe, hs_clk_run, clk_ready};

  csi_tx_hs_clk_lane #(
    .T_LPX(2), .T_PREPARE(3), .T_ZERO(10), .T_POST(4), .T_TRAIL(3), .T_HS_EXIT(5)
  ) dut (
    .byte_clock(clk),
    .reset_n   (reset_n),
    .hs_req    (hs_req),
    .data_busy (data_busy),
    .lp_p      (lp_p),
    .lp_n      (lp_n),
    .hs_oe     (hs_oe),
    .hs_clk_run(hs_clk_run),
    .clk_ready (clk_ready)
  );

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called during cycle N with hs_req high in IDLE; checks cycles N+1..N+16.
  task automatic expect_startup(input string tag);
    logic [4:0] exp;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k <= 2)       exp = OLp01;
      else if (k <= 5)  exp = OLp00;
      else if (k <= 15) exp = OZero;
      else              exp = OClk;
      check($sformatf("%s+%0d", tag, k), obs, exp);
    end
  endtask

  initial begin
    reset_n   = 1'b1;
    hs_req    = 1'b0;
    data_busy = 1'b0;
    #2 reset_n = 1'b0;
    #1 check("reset_async", obs, OIdle);
    step();
    check("reset_hold", obs, OIdle);
    reset_n = 1'b1;

`ifdef CSI_TX_CLK_CONTINUOUS_EN
    for (int k = 1; k <= 17; k++) step();
    check("cont_ready_17", obs, OClk);
    for (int k = 0; k < 1000; k++) begin
      step();
      check("cont_hold", obs, OClk);
    end
`else
    for (int k = 0; k < 3; k++) begin
      step();
      check("idle_noreq", obs, OIdle);
    end

    // Startup from IDLE.
    hs_req = 1'b1;
    expect_startup("startup");
    for (int k = 0; k < 3; k++) begin
      step();
      check("hs_clk_hold", obs, OClk);
    end

    // Stop, with hs_req reasserted during HS_TRAIL (cycle M+6).
    hs_req = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      step();
      if (k <= 4)      check($sformatf("stop+%0d", k), obs, OPost);
      else if (k <= 7) check($sformatf("stop+%0d", k), obs, OZero);
      else             check($sformatf("stop+%0d", k), obs, OIdle);
      if (k == 6) hs_req = 1'b1;
    end
    // Cycle M+13 is the single IDLE cycle; restart follows.
    expect_startup("restart");

    // data_busy holds the clock after hs_req drops.
    hs_req    = 1'b0;
    data_busy = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      check("busy_hold", obs, OClk);
    end
    data_busy = 1'b0;
    step();
    check("busy_release_post", obs, OPost);
    for (int k = 0; k < 12; k++) step();
    check("busy_done_idle", obs, OIdle);

    // Asynchronous reset in HS_ZERO.
    hs_req = 1'b1;
    for (int k = 0; k < 8; k++) step();
    check("zero_before_rst", obs, OZero);
    #2 reset_n = 1'b0;
    #1 check("rst_in_zero", obs, OIdle);
    step();
    check("rst_in_zero_hold", obs, OIdle);
    reset_n = 1'b1;
    expect_startup("post_rst");

    hs_req = 1'b0;
    for (int k = 0; k < 14; k++) step();
    check("final_idle", obs, OIdle);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
